round_controller: RTL and testbench

Match/round sequencer for the fighting game. It gates player controls, resets health between rounds, and runs the pre-round countdown and the round timer. It decides round and match winners from `health_logic` outputs. It runs on the game tick clock (`selected_clk`). Its outputs drive the `fsm` input gating, the `health_logic` reset, and the 7-segment and LED status displays.

---
 rtl/fighting_game_pkg.sv | 33 +++
 rtl/round_controller_sec_tick_counter.sv | 32 +++
 rtl/round_controller.sv | 214 +++++++++++++++++++++
 tb/tb_round_controller.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighting_game_pkg.sv
// Shared types for the fighting game: phase and winner
// encodings plus common datapath widths.
package fighting_game_pkg;

  localparam int HEALTH_W = 2;
  localparam int XPOS_W   = 10;

  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_COUNTDOWN = 3'd1,
    PH_FIGHT     = 3'd2,
    PH_ROUND_END = 3'd3,
    PH_MATCH_END = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  // Higher score wins; ties are a draw.
  function automatic winner_e rank(
    input logic [1:0] a,
    input logic [1:0] b
  );
    if (a > b)      return WIN_P1;
    else if (a < b) return WIN_P2;
    else            return WIN_DRAW;
  endfunction

endpackage

// File: rtl/round_controller_sec_tick_counter.sv
// Free-running modulo-N tick counter; wrap marks one
// elapsed display second.
module sec_tick_counter #(
  parameter int N = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = enable && (cnt_q == W'(N - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (wrap)   cnt_d = '0;
    else if (enable) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/round_controller.sv
// Match/round sequencer: countdown, round timer, KO and
// timeout judging, win tally and match result.
module round_controller
  import fighting_game_pkg::*;
#(
  parameter int TICKS_PER_SEC   = 30,
  parameter int COUNT_START     = 3,
  parameter int ROUND_TIME      = 60,
  parameter int ROUND_END_TICKS = 60,
  parameter int WINS_TO_MATCH   = 2,
  parameter int MAX_ROUNDS      = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                game_over1,
  input  logic                game_over2,
  input  logic [HEALTH_W-1:0] health1,
  input  logic [HEALTH_W-1:0] health2,
  output logic [2:0]          phase,
  output logic                controls_en,
  output logic                health_rst,
  output logic [3:0]          countdown,
  output logic [6:0]          time_left,
  output logic [2:0]          round_num,
  output logic [1:0]          wins1,
  output logic [1:0]          wins2,
  output logic [1:0]          winner,
  output logic                match_over
);

  localparam int HW =
    (ROUND_END_TICKS > 1) ? $clog2(ROUND_END_TICKS) : 1;

  phase_e        phase_q, phase_d;
  winner_e       winner_q, winner_d;
  logic          start_prev_q;
  logic          ctl_q, ctl_d;
  logic          hrst_q, hrst_d;
  logic          mo_q, mo_d;
  logic [3:0]    cd_q, cd_d;
  logic [6:0]    tl_q, tl_d;
  logic [2:0]    rnd_q, rnd_d;
  logic [1:0]    w1_q, w1_d;
  logic [1:0]    w2_q, w2_d;
  logic [HW-1:0] hold_q, hold_d;

  logic    start_edge;
  logic    sec;
  logic    tick_clr;
  logic    tick_en;
  logic    enter_cd;
  logic    end_round;
  logic    match_done;
  winner_e res;

  assign start_edge = start & ~start_prev_q;
  assign match_done = (w1_q == 2'(WINS_TO_MATCH))
                   || (w2_q == 2'(WINS_TO_MATCH))
                   || (rnd_q == 3'(MAX_ROUNDS));

  sec_tick_counter #(
    .N(TICKS_PER_SEC)
  ) u_sec (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clr),
    .enable (tick_en),
    .wrap   (sec)
  );

  always_comb begin
    phase_d   = phase_q;
    winner_d  = winner_q;
    cd_d      = cd_q;
    tl_d      = tl_q;
    rnd_d     = rnd_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    hold_d    = hold_q;
    hrst_d    = 1'b0;
    tick_clr  = 1'b0;
    tick_en   = 1'b0;
    enter_cd  = 1'b0;
    end_round = 1'b0;
    res       = WIN_NONE;

    unique case (phase_q)
      PH_IDLE: begin
        if (start_edge) begin
          rnd_d    = 3'd1;
          w1_d     = '0;
          w2_d     = '0;
          winner_d = WIN_NONE;
          enter_cd = 1'b1;
        end
      end
      PH_COUNTDOWN: begin
        tick_en = 1'b1;
        if (sec) begin
          if (cd_q == 4'd1) begin
            cd_d    = '0;
            phase_d = PH_FIGHT;
          end else begin
            cd_d = cd_q - 4'd1;
          end
        end
      end
      PH_FIGHT: begin
        tick_en = 1'b1;
        // KO outranks a timeout landing on the same tick.
        if (game_over1 | game_over2) begin
          end_round = 1'b1;
          res = (game_over1 & game_over2) ? WIN_DRAW :
                game_over1 ? WIN_P2 : WIN_P1;
        end else if (sec) begin
          if (tl_q == 7'd1) begin
            tl_d      = '0;
            end_round = 1'b1;
            res       = rank(health1, health2);
          end else begin
            tl_d = tl_q - 7'd1;
          end
        end
      end
      PH_ROUND_END: begin
        if (hold_q == HW'(ROUND_END_TICKS - 1)) begin
          if (match_done) begin
            phase_d  = PH_MATCH_END;
            winner_d = rank(w1_q, w2_q);
          end else begin
            rnd_d    = rnd_q + 3'd1;
            enter_cd = 1'b1;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      PH_MATCH_END: begin
        if (start_edge) begin
          rnd_d    = 3'd1;
          w1_d     = '0;
          w2_d     = '0;
          winner_d = WIN_NONE;
          enter_cd = 1'b1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase

    if (enter_cd) begin
      phase_d  = PH_COUNTDOWN;
      tick_clr = 1'b1;
      cd_d     = 4'(COUNT_START);
      tl_d     = 7'(ROUND_TIME);
      hrst_d   = 1'b1;
    end

    if (end_round) begin
      phase_d  = PH_ROUND_END;
      winner_d = res;
      hold_d   = '0;
      if (res == WIN_P1 && w1_q < 2'(WINS_TO_MATCH))
        w1_d = w1_q + 2'd1;
      if (res == WIN_P2 && w2_q < 2'(WINS_TO_MATCH))
        w2_d = w2_q + 2'd1;
    end

    ctl_d = (phase_d == PH_FIGHT);
    mo_d  = (phase_d == PH_MATCH_END);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q      <= PH_IDLE;
      winner_q     <= WIN_NONE;
      start_prev_q <= 1'b1;
      ctl_q        <= 1'b0;
      hrst_q       <= 1'b0;
      mo_q         <= 1'b0;
      cd_q         <= '0;
      tl_q         <= '0;
      rnd_q        <= '0;
      w1_q         <= '0;
      w2_q         <= '0;
      hold_q       <= '0;
    end else begin
      phase_q      <= phase_d;
      winner_q     <= winner_d;
      start_prev_q <= start;
      ctl_q        <= ctl_d;
      hrst_q       <= hrst_d;
      mo_q         <= mo_d;
      cd_q         <= cd_d;
      tl_q         <= tl_d;
      rnd_q        <= rnd_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      hold_q       <= hold_d;
    end
  end

  assign phase       = phase_q;
  assign winner      = winner_q;
  assign controls_en = ctl_q;
  assign health_rst  = hrst_q;
  assign match_over  = mo_q;
  assign countdown   = cd_q;
  assign time_left   = tl_q;
  assign round_num   = rnd_q;
  assign wins1       = w1_q;
  assign wins2       = w2_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with short
// timing parameters (4 ticks/s, 3-2-1, 5 s rounds).
module tb_round_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       game_over1 = 1'b0;
  logic       game_over2 = 1'b0;
  logic [1:0] health1 = 2'd0;
  logic [1:0] health2 = 2'd0;
  logic [2:0] phase;
  logic       controls_en;
  logic       health_rst;
  logic [3:0] countdown;
  logic [6:0] time_left;
  logic [2:0] round_num;
  logic [1:0] wins1;
  logic [1:0] wins2;
  logic [1:0] winner;
  logic       match_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  round_controller #(
    .TICKS_PER_SEC   (4),
    .COUNT_START     (3),
    .ROUND_TIME      (5),
    .ROUND_END_TICKS (4),
    .WINS_TO_MATCH   (2),
    .MAX_ROUNDS      (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .game_over1  (game_over1),
    .game_over2  (game_over2),
    .health1     (health1),
    .health2     (health2),
    .phase       (phase),
    .controls_en (controls_en),
    .health_rst  (health_rst),
    .countdown   (countdown),
    .time_left   (time_left),
    .round_num   (round_num),
    .wins1       (wins1),
    .wins2       (wins2),
    .winner      (winner),
    .match_over  (match_over)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // From countdown cycle 1 into fight cycle 1; game_over
  // is asserted throughout and must be ignored.
  task automatic run_countdown;
    game_over1 = 1'b1;
    step(11);
    checks++;
    if (phase !== 3'd1) begin
      errors++;
      $display("FAIL cd_ignore_ko got %0d exp 1", phase);
    end
    game_over1 = 1'b0;
    step(1);
    checks++;
    if (phase !== 3'd2 || controls_en !== 1'b1) begin
      errors++;
      $display("FAIL cd_to_fight got %0d/%0b exp 2/1",
               phase, controls_en);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b1;
    step(2);
    checks++;
    if ({phase, controls_en, health_rst, countdown,
         time_left, round_num, wins1, wins2, winner,
         match_over} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero phase %0d",
               phase);
    end
    reset = 1'b1;
    step(3);
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL start_held got %0d exp 0", phase);
    end
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (phase !== 3'd1 || health_rst !== 1'b1 ||
        countdown !== 4'd3 || round_num !== 3'd1) begin
      errors++;
      $display("FAIL start_press got %0d/%0b/%0d/%0d exp 1/1/3/1",
               phase, health_rst, countdown, round_num);
    end
  endtask

  task automatic test_countdown;
    logic [3:0] exp_cd;
    for (int k = 2; k <= 12; k++) begin
      step(1);
      exp_cd = 4'(3 - (k - 1) / 4);
      checks++;
      if (countdown !== exp_cd || phase !== 3'd1) begin
        errors++;
        $display("FAIL countdown_%0d got %0d exp %0d",
                 k, countdown, exp_cd);
      end
      if (k == 2) begin
        checks++;
        if (health_rst !== 1'b0) begin
          errors++;
          $display("FAIL health_rst_pulse got 1 exp 0");
        end
      end
    end
    step(1);
    checks++;
    if (phase !== 3'd2 || countdown !== 4'd0 ||
        controls_en !== 1'b1 || time_left !== 7'd5) begin
      errors++;
      $display("FAIL fight_entry got %0d/%0d/%0b/%0d exp 2/0/1/5",
               phase, countdown, controls_en, time_left);
    end
  endtask

  task automatic test_ko_p1;
    step(5);
    checks++;
    if (time_left !== 7'd4) begin
      errors++;
      $display("FAIL ko_time got %0d exp 4", time_left);
    end
    game_over2 = 1'b1;
    step(1);
    game_over2 = 1'b0;
    checks++;
    if (phase !== 3'd3 || winner !== 2'b01 ||
        wins1 !== 2'd1 || controls_en !== 1'b0) begin
      errors++;
      $display("FAIL ko_p1 got %0d/%0d/%0d/%0b exp 3/1/1/0",
               phase, winner, wins1, controls_en);
    end
    step(3);
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("FAIL hold got %0d exp 3", phase);
    end
    step(1);
    checks++;
    if (phase !== 3'd1 || round_num !== 3'd2 ||
        health_rst !== 1'b1 || time_left !== 7'd5) begin
      errors++;
      $display("FAIL round2 got %0d/%0d/%0b/%0d exp 1/2/1/5",
               phase, round_num, health_rst, time_left);
    end
  endtask

  task automatic test_timeout;
    logic [6:0] exp_tl;
    run_countdown();
    health1 = 2'd2;
    health2 = 2'd3;
    for (int c = 2; c <= 20; c++) begin
      step(1);
      exp_tl = 7'(5 - (c - 1) / 4);
      checks++;
      if (time_left !== exp_tl) begin
        errors++;
        $display("FAIL time_left_%0d got %0d exp %0d",
                 c, time_left, exp_tl);
      end
    end
    step(1);
    checks++;
    if (phase !== 3'd3 || time_left !== 7'd0 ||
        winner !== 2'b10 || wins2 !== 2'd1 ||
        wins1 !== 2'd1) begin
      errors++;
      $display("FAIL timeout_p2 got %0d/%0d/%0d/%0d%0d exp 3/0/2/11",
               phase, time_left, winner, wins1, wins2);
    end
    step(4);
    checks++;
    if (phase !== 3'd1 || round_num !== 3'd3) begin
      errors++;
      $display("FAIL round3 got %0d/%0d exp 1/3",
               phase, round_num);
    end
  endtask

  task automatic test_draw_priority;
    run_countdown();
    health1 = 2'd3;
    health2 = 2'd0;
    step(19);
    checks++;
    if (time_left !== 7'd1) begin
      errors++;
      $display("FAIL last_sec got %0d exp 1", time_left);
    end
    game_over1 = 1'b1;
    game_over2 = 1'b1;
    step(1);
    game_over1 = 1'b0;
    game_over2 = 1'b0;
    checks++;
    if (winner !== 2'b11 || wins1 !== 2'd1 ||
        wins2 !== 2'd1 || phase !== 3'd3) begin
      errors++;
      $display("FAIL ko_over_timeout got %0d/%0d%0d exp 3/11",
               winner, wins1, wins2);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("FAIL start_ignored got %0d exp 3", phase);
    end
    step(2);
    checks++;
    if (phase !== 3'd4 || match_over !== 1'b1 ||
        winner !== 2'b11 || controls_en !== 1'b0) begin
      errors++;
      $display("FAIL limit_match got %0d/%0b/%0d exp 4/1/3",
               phase, match_over, winner);
    end
  endtask

  task automatic test_restart;
    step(2);
    checks++;
    if (phase !== 3'd4) begin
      errors++;
      $display("FAIL match_hold got %0d exp 4", phase);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (phase !== 3'd1 || wins1 !== 2'd0 ||
        wins2 !== 2'd0 || round_num !== 3'd1 ||
        match_over !== 1'b0) begin
      errors++;
      $display("FAIL restart got %0d/%0d%0d/%0d exp 1/00/1",
               phase, wins1, wins2, round_num);
    end
  endtask

  task automatic test_p1_match;
    for (int r = 1; r <= 2; r++) begin
      run_countdown();
      game_over2 = 1'b1;
      step(1);
      game_over2 = 1'b0;
      checks++;
      if (winner !== 2'b01 || wins1 !== 2'(r)) begin
        errors++;
        $display("FAIL p1_round%0d got %0d/%0d exp 1/%0d",
                 r, winner, wins1, r);
      end
      step(4);
    end
    checks++;
    if (phase !== 3'd4 || match_over !== 1'b1 ||
        winner !== 2'b01 || wins1 !== 2'd2) begin
      errors++;
      $display("FAIL p1_match got %0d/%0b/%0d/%0d exp 4/1/1/2",
               phase, match_over, winner, wins1);
    end
  endtask

  task automatic test_draw_match;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      run_countdown();
      game_over1 = 1'b1;
      game_over2 = 1'b1;
      step(1);
      game_over1 = 1'b0;
      game_over2 = 1'b0;
      checks++;
      if (winner !== 2'b11 || wins1 !== 2'd0 ||
          wins2 !== 2'd0 || round_num !== 3'(r)) begin
        errors++;
        $display("FAIL draw_round%0d got %0d/%0d%0d/%0d exp 3/00/%0d",
                 r, winner, wins1, wins2, round_num, r);
      end
      step(4);
    end
    checks++;
    if (phase !== 3'd4 || winner !== 2'b11 ||
        match_over !== 1'b1) begin
      errors++;
      $display("FAIL draw_match got %0d/%0d exp 4/3",
               phase, winner);
    end
  endtask

  task automatic test_mid_reset;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (phase !== 3'd1 || health_rst !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got %0d/%0b exp 1/1",
               phase, health_rst);
    end
    reset = 1'b0;
    step(1);
    checks++;
    if ({phase, controls_en, health_rst, countdown,
         time_left, round_num, wins1, wins2, winner,
         match_over} !== '0) begin
      errors++;
      $display("FAIL mid_reset got phase %0d rst %0b cd %0d",
               phase, health_rst, countdown);
    end
    reset = 1'b1;
    step(2);
    checks++;
    if (phase !== 3'd0) begin
      errors++;
      $display("FAIL post_reset got %0d exp 0", phase);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_ko_p1();
    test_timeout();
    test_draw_priority();
    test_restart();
    test_p1_match();
    test_draw_match();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
